// File: rtl/fetch_queue_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_unit_if
// Bundles the instruction-memory, redirect and decode-side handshake signals of
// the fetch stage.
//   master : fetch stage side (drives imem_req/imem_addr and the inst_* outputs)
//   slave  : environment side (instruction memory, redirect source, decode)
// Signals:
//   imem_req, imem_addr    fetch request and address
//   imem_rdata             instruction returned one cycle after a request
//   redirect_valid/pc      taken branch/jump, flush and refetch from pc
//   inst_valid/ready       decode handshake for the queue head
//   inst_data, inst_pc     instruction and PC at the queue head
// -----------------------------------------------------------------------------
interface fetch_queue_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output inst_valid,
    input  inst_ready,
    output inst_data,
    output inst_pc
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  inst_valid,
    output inst_ready,
    input  inst_data,
    input  inst_pc
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// -----------------------------------------------------------------------------
// fetch_queue_unit
// Instruction-fetch stage: generates sequential fetch PCs, issues requests to a
// synchronous-read instruction memory (fixed 1-cycle latency), buffers the
// returned instructions with their PCs in a DEPTH-entry FIFO and hands them to
// decode over valid/ready. A redirect flushes queued and in-flight fetches.
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    fetch_queue_unit_if.master (imem, redirect and decode signals)
// -----------------------------------------------------------------------------
module fetch_queue_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] PC_RESET = {XLEN{1'b0}},
  parameter logic [XLEN-1:0] PC_STEP  = XLEN'(32'd4)
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_queue_unit_if.master bus
);

  localparam int unsigned     AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     CW         = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]   DEPTH_C    = CW'(DEPTH);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(2'b11));

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FLUSH = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            inflight_q, inflight_d;
  logic            inflight_epoch_q, inflight_epoch_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            epoch_q, epoch_d;
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] mem_pc_q   [DEPTH];
  logic [XLEN-1:0] mem_data_q [DEPTH];

  logic            active_s;
  logic            redirect_s;
  logic [CW-1:0]   occupancy_s;
  logic            issue_s;
  logic            push_s;
  logic            inst_valid_s;
  logic            pop_s;

  // Requests and redirects are only honoured once the boot cycle is over.
  assign active_s    = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign redirect_s  = bus.redirect_valid && active_s;
  // Slots already claimed: queued entries plus the response still on its way.
  assign occupancy_s = count_q + {{(CW-1){1'b0}}, inflight_q};
  assign issue_s     = active_s && !bus.redirect_valid && (occupancy_s < DEPTH_C);
  // A response belongs to the current stream only if its epoch tag matches.
  assign push_s      = inflight_q && (inflight_epoch_q == epoch_q) && !redirect_s;
  assign inst_valid_s = (count_q != {CW{1'b0}}) && !bus.redirect_valid;
  assign pop_s       = inst_valid_s && bus.inst_ready && !redirect_s;

  assign bus.imem_req   = issue_s;
  assign bus.imem_addr  = fetch_pc_q;
  assign bus.inst_valid = inst_valid_s;
  assign bus.inst_data  = mem_data_q[head_q];
  assign bus.inst_pc    = mem_pc_q[head_q];

  // FSM next-state: one boot cycle, then RUN with a one-cycle FLUSH per redirect.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_s) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (redirect_s) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // Datapath next-state: fetch PC, in-flight tracking, epoch and FIFO pointers.
  always_comb begin
    fetch_pc_d       = fetch_pc_q;
    inflight_d       = 1'b0;
    inflight_epoch_d = inflight_epoch_q;
    inflight_pc_d    = inflight_pc_q;
    epoch_d          = epoch_q;
    head_d           = head_q;
    tail_d           = tail_q;
    count_d          = count_q;
    if (redirect_s) begin
      // Keep head in place so inst_data/inst_pc hold while the queue is empty.
      fetch_pc_d = bus.redirect_pc & ALIGN_MASK;
      epoch_d    = ~epoch_q;
      tail_d     = head_q;
      count_d    = {CW{1'b0}};
    end else begin
      if (issue_s) begin
        fetch_pc_d       = fetch_pc_q + PC_STEP;
        inflight_d       = 1'b1;
        inflight_epoch_d = epoch_q;
        inflight_pc_d    = fetch_pc_q;
      end else begin
        inflight_d = 1'b0;
      end
      if (push_s) begin
        tail_d = tail_q + AW'(1'b1);
      end else begin
        tail_d = tail_q;
      end
      if (pop_s) begin
        head_d = head_q + AW'(1'b1);
      end else begin
        head_d = head_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1'b1);
        2'b01:   count_d = count_q - CW'(1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_BOOT;
      fetch_pc_q       <= PC_RESET;
      inflight_q       <= 1'b0;
      inflight_epoch_q <= 1'b0;
      inflight_pc_q    <= {XLEN{1'b0}};
      epoch_q          <= 1'b0;
      head_q           <= {AW{1'b0}};
      tail_q           <= {AW{1'b0}};
      count_q          <= {CW{1'b0}};
    end else begin
      state_q          <= state_d;
      fetch_pc_q       <= fetch_pc_d;
      inflight_q       <= inflight_d;
      inflight_epoch_q <= inflight_epoch_d;
      inflight_pc_q    <= inflight_pc_d;
      epoch_q          <= epoch_d;
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
    end
  end

  // Queue storage; cleared on reset so the head outputs read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_pc_q[i]   <= {XLEN{1'b0}};
        mem_data_q[i] <= {XLEN{1'b0}};
      end
    end else if (push_s) begin
      mem_pc_q[tail_q]   <= inflight_pc_q;
      mem_data_q[tail_q] <= bus.imem_rdata;
    end
  end

endmodule
